// File: rtl/shot_controller.sv
// shot_controller: player fire control. Turns the fire key into 1-cycle shot
// pulses, gated by a frame cooldown, an ammo magazine with timed reload and
// an optional one-missile-on-screen rule.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_enable              game-running qualifier (0 freezes the controller)
//   i_startOfFrame        1-cycle pulse per frame
//   i_fire_key            synchronised fire key level
//   i_missile_active      feedback from missile_movement
//   o_shooting_pulse      1-cycle shot request
//   o_ammo_count          shots remaining in the magazine
//   o_reloading           high while the magazine is refilling
//   o_cooldown_active     high while waiting between shots
//
// Build option: define SHOT_AUTOFIRE_EN to treat the fire key level (not its
// rising edge) as a request, so a held key keeps firing.

module shot_controller #(
    parameter int MAX_AMMO        = 5,
    parameter int AMMO_WIDTH      = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int RELOAD_FRAMES   = 60,
    parameter int SINGLE_MISSILE  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_startOfFrame,
    input  logic                  i_fire_key,
    input  logic                  i_missile_active,
    output logic                  o_shooting_pulse,
    output logic [AMMO_WIDTH-1:0] o_ammo_count,
    output logic                  o_reloading,
    output logic                  o_cooldown_active
);

    localparam int CNT_MAX = (COOLDOWN_FRAMES > RELOAD_FRAMES) ?
                             COOLDOWN_FRAMES : RELOAD_FRAMES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]         CD_LOAD   = CW'(COOLDOWN_FRAMES);
    localparam logic [CW-1:0]         RL_LOAD   = CW'(RELOAD_FRAMES);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [AMMO_WIDTH-1:0] AMMO_FULL = AMMO_WIDTH'(MAX_AMMO);
    localparam logic [AMMO_WIDTH-1:0] AMMO_ONE  = AMMO_WIDTH'(1);

    typedef enum logic [1:0] {
        S_READY,
        S_FIRE,
        S_COOLDOWN,
        S_RELOAD
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AMMO_WIDTH-1:0] r_ammo;
    logic [AMMO_WIDTH-1:0] w_ammo_next;
    logic [AMMO_WIDTH-1:0] w_ammo_dec;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic                  r_pending;
    logic                  w_pending_next;
    logic                  r_key_d;
    logic                  r_pulse;
    logic                  r_cool;
    logic                  r_reload;
    logic                  w_req;
    logic                  w_blocked;

`ifdef SHOT_AUTOFIRE_EN
    assign w_req = i_fire_key;
`else
    assign w_req = i_fire_key & ~r_key_d;
`endif

    assign w_blocked  = (SINGLE_MISSILE != 0) && i_missile_active;
    assign w_ammo_dec = r_ammo - AMMO_ONE;

    always_comb begin
        w_next         = r_state;
        w_ammo_next    = r_ammo;
        w_cnt_next     = r_cnt;
        // pending only survives in READY; enable=0 also drops it
        w_pending_next = 1'b0;
        if (i_enable) begin
            unique case (r_state)
                S_READY: begin
                    if (r_pending && (r_ammo != '0) && !w_blocked) begin
                        w_next = S_FIRE;
                    end else begin
                        w_pending_next = r_pending | w_req;
                    end
                end
                S_FIRE: begin
                    w_ammo_next = w_ammo_dec;
                    if (w_ammo_dec == '0) begin
                        w_next     = S_RELOAD;
                        w_cnt_next = RL_LOAD;
                    end else if (COOLDOWN_FRAMES == 0) begin
                        w_next = S_READY;
                    end else begin
                        w_next     = S_COOLDOWN;
                        w_cnt_next = CD_LOAD;
                    end
                end
                S_COOLDOWN, S_RELOAD: begin
                    if (i_startOfFrame) begin
                        // <=1 also catches 0 so the counter cannot wrap
                        if (r_cnt <= CNT_ONE) begin
                            w_cnt_next = '0;
                            w_next     = S_READY;
                            if (r_state == S_RELOAD) begin
                                w_ammo_next = AMMO_FULL;
                            end
                        end else begin
                            w_cnt_next = r_cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_next = S_READY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_READY;
            r_ammo    <= AMMO_FULL;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_key_d   <= 1'b0;
            r_pulse   <= 1'b0;
            r_cool    <= 1'b0;
            r_reload  <= 1'b0;
        end else begin
            r_key_d   <= i_fire_key;
            r_state   <= w_next;
            r_ammo    <= w_ammo_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
            r_pulse   <= i_enable && (w_next == S_FIRE);
            r_cool    <= (w_next == S_COOLDOWN);
            r_reload  <= (w_next == S_RELOAD);
        end
    end

    assign o_shooting_pulse  = r_pulse;
    assign o_ammo_count      = r_ammo;
    assign o_reloading       = r_reload;
    assign o_cooldown_active = r_cool;

endmodule

// File: tb/tb_shot_controller.sv
// tb_shot_controller: table vectors, directed scenarios and random stimulus
// for shot_controller, checked against a frame/ammo reference model.

module tb_shot_controller;

    localparam int MAXA = 5;
    localparam int CD   = 8;
    localparam int RL   = 60;
    localparam int SM   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sof = 1'b0;
    logic       key = 1'b0;
    logic       miss = 1'b0;
    logic       o_pulse;
    logic [3:0] o_ammo;
    logic       o_rl;
    logic       o_cd;

    int n_chk = 0;
    int n_fail = 0;
    int n_pulse = 0;
    int fc = 0;

    // reference model: ammo left, frames still to wait, a pending request
    // and a "shot in progress" flag
    int m_ammo = MAXA;
    int m_wait = 0;
    bit m_pend = 0;
    bit m_kd = 0;
    bit m_fire = 0;
    bit m_pulse = 0;

    shot_controller dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_enable         (en),
        .i_startOfFrame   (sof),
        .i_fire_key       (key),
        .i_missile_active (miss),
        .o_shooting_pulse (o_pulse),
        .o_ammo_count     (o_ammo),
        .o_reloading      (o_rl),
        .o_cooldown_active(o_cd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_step();
        bit req;
        if (rst) begin
            m_ammo = MAXA; m_wait = 0; m_pend = 0;
            m_kd = 0; m_fire = 0; m_pulse = 0;
            return;
        end
`ifdef SHOT_AUTOFIRE_EN
        req = key;
`else
        req = key && !m_kd;
`endif
        m_kd = key;
        m_pulse = 0;
        if (!en) begin
            m_pend = 0;
            return;
        end
        if (m_fire) begin
            m_fire = 0;
            m_ammo = m_ammo - 1;
            m_pend = 0;
            m_wait = (m_ammo == 0) ? RL : CD;
        end else if (m_wait > 0) begin
            m_pend = 0;
            if (sof) begin
                m_wait = m_wait - 1;
                if (m_wait == 0 && m_ammo == 0) m_ammo = MAXA;
            end
        end else if (m_pend && !(SM != 0 && miss)) begin
            m_fire = 1;
            m_pend = 0;
            m_pulse = 1;
        end else if (req) begin
            m_pend = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        if (o_pulse === 1'b1) n_pulse++;
        chk("pulse", 8'(o_pulse), 8'(m_pulse));
        chk("ammo", 8'(o_ammo), 8'(m_ammo));
        chk("cooldown", 8'(o_cd), 8'(m_wait > 0 && m_ammo > 0));
        chk("reloading", 8'(o_rl), 8'(m_wait > 0 && m_ammo == 0));
    endtask

    // one clock with a startOfFrame every 4th cycle
    task automatic cyc(input logic k);
        key = k;
        sof = (fc == 0);
        fc = (fc + 1) % 4;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; key = 1'b0; en = 1'b1; miss = 1'b0; sof = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic tap_gap(input int gap);
        cyc(1'b1);
        for (int i = 0; i < gap; i++) cyc(1'b0);
    endtask

    typedef struct {
        logic       rst;
        logic       key;
        logic       sof;
        logic       pulse;
        logic [3:0] ammo;
        logic       cd;
        logic       rl;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 5, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 5, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 5, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[5]  = '{0, 1, 0, 0, 4, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[8]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[9]  = '{0, 0, 1, 0, 4, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 4, 1, 0};
        tbl[11] = '{0, 0, 1, 0, 4, 1, 0};
        tbl[12] = '{0, 0, 1, 0, 4, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 4, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 4, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 4, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 3, 1, 0};

        // tap, cooldown of 8 frames, tap during cooldown ignored
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; key = tbl[i].key; sof = tbl[i].sof;
            tick();
            chk($sformatf("tbl%0d_pulse", i), 8'(o_pulse), 8'(tbl[i].pulse));
            chk($sformatf("tbl%0d_ammo", i), 8'(o_ammo), 8'(tbl[i].ammo));
            chk($sformatf("tbl%0d_cd", i), 8'(o_cd), 8'(tbl[i].cd));
            chk($sformatf("tbl%0d_rl", i), 8'(o_rl), 8'(tbl[i].rl));
        end

        // five spaced taps empty the magazine, reload then refire
        do_reset();
        n_pulse = 0;
        for (int s = 0; s < 5; s++) tap_gap(40);
        chk("drain_pulses", 8'(n_pulse), 8'd5);
        chk("drain_ammo", 8'(o_ammo), 8'd0);
        chk("drain_reloading", 8'(o_rl), 8'd1);
        for (int i = 0; i < RL * 4; i++) cyc(1'b0);
        chk("refill_ammo", 8'(o_ammo), 8'd5);
        chk("refill_reloading", 8'(o_rl), 8'd0);
        n_pulse = 0;
        tap_gap(5);
        chk("refire_pulses", 8'(n_pulse), 8'd1);

        // reset in the middle of a reload
        do_reset();
        for (int s = 0; s < 4; s++) tap_gap(40);
        tap_gap(3);
        for (int i = 0; i < 120; i++) cyc(1'b0);
        chk("mid_reload", 8'(o_rl), 8'd1);
        rst = 1'b1;
        tick();
        chk("rst_ammo", 8'(o_ammo), 8'd5);
        chk("rst_reloading", 8'(o_rl), 8'd0);
        chk("rst_pulse", 8'(o_pulse), 8'd0);
        rst = 1'b0;

        // missile on screen holds the request until it clears
        do_reset();
        miss = 1'b1;
        n_pulse = 0;
        tap_gap(10);
        chk("blocked_pulses", 8'(n_pulse), 8'd0);
        miss = 1'b0;
        cyc(1'b0);
        chk("unblocked_pulse", 8'(o_pulse), 8'd1);

        // key held for 40 frames
        do_reset();
        n_pulse = 0;
        for (int i = 0; i < 160; i++) cyc(1'b1);
`ifdef SHOT_AUTOFIRE_EN
        chk("hold_multi", 8'(n_pulse > 1), 8'd1);
`else
        chk("hold_single", 8'(n_pulse), 8'd1);
`endif

        // key held across an enable rise
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1'b1);
        en = 1'b1;
        n_pulse = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1);
`ifndef SHOT_AUTOFIRE_EN
        chk("enable_rise", 8'(n_pulse), 8'd0);
`endif

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 399) == 0);
            en   = ($urandom_range(0, 19) != 0);
            sof  = ($urandom_range(0, 2) == 0);
            miss = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) key = ~key;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
